// File: rtl/mfc_pkg.sv
// Shared types for the mfc2 comparator driver: FSM states and the captured result layout.
package mfc_pkg;

    localparam int MFC_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } mfc_state_e;

    typedef struct packed {
        logic                   eq;
        logic                   ae;
        logic                   gt;
        logic [MFC_WIDTH/4-1:0] d;
    } mfc_result_t;

endpackage

// File: rtl/mfc_driver.sv
// Clocked, flow-controlled initiator for a delay-modelled mfc2 compare core:
// accept a pair, hold it on the bus for SETTLE_CYCLES, capture the flags, return them.
module mfc_driver
    import mfc_pkg::*;
#(
    parameter int WIDTH         = MFC_WIDTH,
    parameter int SETTLE_CYCLES = 30,
    parameter int CNT_W         = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic [WIDTH-1:0]   cmp_a,
    output logic [WIDTH-1:0]   cmp_b,
    input  logic               cmp_eq,
    input  logic               cmp_ae,
    input  logic               cmp_gt,
    input  logic [WIDTH/4-1:0] cmp_d,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_eq,
    output logic               out_ae,
    output logic               out_gt,
    output logic [WIDTH/4-1:0] out_d,
    output logic               busy,
    output logic [CNT_W-1:0]   done_cnt
);

    localparam int DW = WIDTH / 4;
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);

    mfc_state_e       state_q, state_d;
    logic [SW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             eq_q, eq_d, ae_q, ae_d, gt_q, gt_d;
    logic [DW-1:0]    d_q, d_d;
    logic             vld_q, vld_d;
    logic [CNT_W-1:0] done_q, done_d;

    assign in_ready = (state_q == ST_IDLE) && !rst;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        eq_d    = eq_q;
        ae_d    = ae_q;
        gt_d    = gt_q;
        d_d     = d_q;
        vld_d   = vld_q;
        done_d  = done_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    cnt_d   = SETTLE_LOAD;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                // Counter reaching zero marks the last cycle of the settle window.
                if (cnt_q == '0) begin
                    eq_d    = cmp_eq;
                    ae_d    = cmp_ae;
                    gt_d    = cmp_gt;
                    d_d     = cmp_d;
                    vld_d   = 1'b1;
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    vld_d   = 1'b0;
                    done_d  = done_q + 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            eq_q    <= 1'b0;
            ae_q    <= 1'b0;
            gt_q    <= 1'b0;
            d_q     <= '0;
            vld_q   <= 1'b0;
            done_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            eq_q    <= eq_d;
            ae_q    <= ae_d;
            gt_q    <= gt_d;
            d_q     <= d_d;
            vld_q   <= vld_d;
            done_q  <= done_d;
        end
    end

    assign cmp_a     = a_q;
    assign cmp_b     = b_q;
    assign out_valid = vld_q;
    assign out_eq    = eq_q;
    assign out_ae    = ae_q;
    assign out_gt    = gt_q;
    assign out_d     = d_q;
    assign busy      = (state_q != ST_IDLE);
    assign done_cnt  = done_q;

endmodule
